// File: rtl/dffram_req_ctrl_if.sv
// dffram_req_ctrl_if: request/response handshake bundle between a client and dffram_req_ctrl.
interface dffram_req_ctrl_if #(
    parameter int AW    = 8,
    parameter int WSIZE = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [WSIZE-1:0]   req_we;
    logic [AW-1:0]      req_addr;
    logic [8*WSIZE-1:0] req_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [8*WSIZE-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dffram_req_ctrl.sv
// dffram_req_ctrl: sole driver of a single-port DFFRAM, valid/ready requests in, read data via a response FIFO.
// Define INIT_CLEAR_EN to zero-fill the whole array after every reset before traffic is accepted.
//
// state   | meaning
// ST_INIT | post-reset sweep writing zero to every word (INIT_CLEAR_EN only)
// ST_RUN  | normal request/response traffic
module dffram_req_ctrl #(
    parameter int AW        = 8,
    parameter int WSIZE     = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dffram_req_ctrl_if.slave   bus,
    output logic               ram_en0_o,
    output logic [WSIZE-1:0]   ram_we0_o,
    output logic [AW-1:0]      ram_a0_o,
    output logic [8*WSIZE-1:0] ram_di0_o,
    input  logic [8*WSIZE-1:0] ram_do0_i,
    output logic               init_done_o
);
    localparam int DW = 8 * WSIZE;
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(RSP_DEPTH);

    logic              run;
    logic              credit_ok;
    logic              accept;
    logic              accept_rd;
    logic              push;
    logic              pop;
    logic [CW:0]       occupancy;

    logic              init_done_q, init_done_d;
    logic              inflight_q,  inflight_d;
    logic [CW-1:0]     count_q,     count_d;
    logic [PW-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [DW-1:0]     fifo_q [RSP_DEPTH];

`ifdef INIT_CLEAR_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q,     state_d;
    logic [AW-1:0] init_addr_q, init_addr_d;
    logic          sweep;

    assign sweep = (state_q == ST_INIT);
    assign run   = (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_done_d = init_done_q;
        if (sweep) begin
            init_addr_d = init_addr_q + AW'(1);
            if (&init_addr_q) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            init_done_q <= init_done_d;
        end
    end
`else
    assign init_done_d = 1'b1;
    assign run         = init_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= init_done_d;
        end
    end
`endif

    assign init_done_o = init_done_q;

    // Credits count both stored and in-flight reads so the FIFO can never overflow.
    assign occupancy     = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign credit_ok     = (occupancy < DEPTH_C);
    assign bus.req_ready = run & credit_ok;
    assign accept        = bus.req_valid & bus.req_ready;
    assign accept_rd     = accept & ~(|bus.req_we);

    always_comb begin
        ram_en0_o = accept;
        ram_we0_o = accept ? bus.req_we : '0;
        ram_a0_o  = bus.req_addr;
        ram_di0_o = bus.req_wdata;
`ifdef INIT_CLEAR_EN
        if (sweep) begin
            ram_en0_o = ~rst_i;
            ram_we0_o = '1;
            ram_a0_o  = init_addr_q;
            ram_di0_o = '0;
        end
`endif
    end

    // The RAM presents read data the cycle after the strobe, so the push lags acceptance by one edge.
    assign push          = inflight_q;
    assign pop           = bus.rsp_valid & bus.rsp_ready;
    assign bus.rsp_valid = (count_q != '0);
    assign bus.rsp_rdata = fifo_q[rd_ptr_q];

    always_comb begin
        inflight_d = accept_rd;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= ram_do0_i;
        end
    end
endmodule

// File: tb/tb_dffram_req_ctrl.sv
// Bench for dffram_req_ctrl: behavioural RAM, transaction-level model checked every cycle, plus literal checks.
module tb_dffram_req_ctrl;
    localparam int AW        = 8;
    localparam int WSIZE     = 4;
    localparam int RSP_DEPTH = 4;
`ifdef INIT_CLEAR_EN
    localparam bit INIT_BUILD  = 1'b1;
    localparam int INIT_CYCLES = 256;
`else
    localparam bit INIT_BUILD  = 1'b0;
    localparam int INIT_CYCLES = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_en0;
    logic [3:0]  ram_we0;
    logic [7:0]  ram_a0;
    logic [31:0] ram_di0;
    logic [31:0] ram_do0;
    logic        init_done;

    dffram_req_ctrl_if #(.AW(AW), .WSIZE(WSIZE)) bus();

    dffram_req_ctrl #(.AW(AW), .WSIZE(WSIZE), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .ram_en0_o   (ram_en0),
        .ram_we0_o   (ram_we0),
        .ram_a0_o    (ram_a0),
        .ram_di0_o   (ram_di0),
        .ram_do0_i   (ram_do0),
        .init_done_o (init_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural DFFRAM: registered read, byte-masked write at the strobe edge.
    logic [31:0] ram_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 32'hC0DE0000 | i;
        forever begin
            @(posedge clk);
            if (ram_en0) begin
                if (ram_we0 == 4'b0000) ram_do0 <= ram_mem[ram_a0];
                for (int b = 0; b < WSIZE; b++)
                    if (ram_we0[b]) ram_mem[ram_a0][8*b +: 8] <= ram_di0[8*b +: 8];
            end
        end
    end

    // Transaction model: expected memory image and queue of outstanding read responses.
    logic [31:0] exp_mem [256];
    logic [31:0] rq_data [$];
    int          rq_vis  [$];
    int          cyc      = 0;
    int          init_cnt = 0;
    logic [31:0] got_q   [$];
    int          got_cyc [$];
    int          acc_cnt  = 0;

    initial begin
        logic exp_done, exp_rdy, exp_rv, exp_acc;
        for (int i = 0; i < 256; i++) exp_mem[i] = 32'hC0DE0000 | i;
        forever begin
            @(negedge clk);
            exp_done = (init_cnt >= INIT_CYCLES);
            exp_rdy  = exp_done && (rq_data.size() < RSP_DEPTH);
            exp_rv   = (rq_data.size() != 0) && (rq_vis[0] <= cyc);
            exp_acc  = bus.req_valid && exp_rdy;
            chk("init_done", init_done, exp_done);
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("rsp_valid", bus.rsp_valid, exp_rv);
            if (exp_rv) chk("rsp_rdata", bus.rsp_rdata, rq_data[0]);
`ifdef INIT_CLEAR_EN
            if (!exp_done) begin
                chk("sweep_en0", ram_en0, !rst);
                if (!rst) begin
                    chk("sweep_a0", ram_a0, init_cnt[7:0]);
                    chk("sweep_we0", ram_we0, 4'hF);
                    chk("sweep_di0", ram_di0, 32'h0);
                end
            end else
`endif
            begin
                chk("ram_en0", ram_en0, exp_acc);
                chk("ram_we0", ram_we0, exp_acc ? bus.req_we : 4'h0);
                if (exp_acc) begin
                    chk("ram_a0", ram_a0, bus.req_addr);
                    chk("ram_di0", ram_di0, bus.req_wdata);
                end
            end

            if (bus.rsp_valid && bus.rsp_ready) begin
                got_q.push_back(bus.rsp_rdata);
                got_cyc.push_back(cyc);
            end
            if (bus.req_valid && bus.req_ready) acc_cnt++;

            if (rst) begin
                rq_data.delete();
                rq_vis.delete();
                init_cnt = 0;
`ifdef INIT_CLEAR_EN
                for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;
`endif
            end else begin
                if (exp_rv && bus.rsp_ready) begin
                    void'(rq_data.pop_front());
                    void'(rq_vis.pop_front());
                end
                if (exp_acc) begin
                    if (bus.req_we == 4'b0000) begin
                        rq_data.push_back(exp_mem[bus.req_addr]);
                        rq_vis.push_back(cyc + 2);
                    end else begin
                        for (int b = 0; b < WSIZE; b++)
                            if (bus.req_we[b]) exp_mem[bus.req_addr][8*b +: 8] = bus.req_wdata[8*b +: 8];
                    end
                end
                if (init_cnt < INIT_CYCLES) init_cnt++;
            end
            cyc++;
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 4'h0;
    endtask

    task automatic issue(input logic [3:0] we, input logic [7:0] addr, input logic [31:0] data,
                         output int waits);
        bit acc;
        waits = 0;
        acc   = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        while (!acc) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 200) begin
                    chk("accept_timeout", bus.req_ready, 1'b1);
                    acc = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_init(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (init_done) break;
            n++;
            if (n > 400) begin
                chk("init_timeout", init_done, 1'b1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int          w, lat, n, stalls;
        logic [31:0] bp_exp [6];
        bp_exp[0] = 32'hAA3355BB; bp_exp[1] = 32'hAA0033CC; bp_exp[2] = 32'hAA005533;
        bp_exp[3] = 32'h11110000; bp_exp[4] = 32'h22220001; bp_exp[5] = 32'h33330002;

        bus.req_valid = 1'b0;
        bus.req_we    = 4'h0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        step(3);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        step(1);
        rst = 1'b0;
        wait_init(n);
        chk("init_latency", n, INIT_CYCLES);

        // Full-word writes and a timed readback.
        issue(4'hF, 8'h00, 32'hAA0055BB, w);
        issue(4'hF, 8'h01, 32'hAA0055CC, w);
        issue(4'hF, 8'h02, 32'hAA0055DD, w);
        issue(4'h0, 8'h00, 32'h0, w);
        idle();
        lat = 1;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            lat++;
            if (lat > 20) break;
            @(posedge clk);
            #1;
        end
        chk("rd_latency", lat, 2);
        chk("rd_data0", bus.rsp_rdata, 32'hAA0055BB);
        step(1);

        // Byte-masked writes, then ordered readback.
        issue(4'b0001, 8'h02, 32'h00000033, w);
        issue(4'b0010, 8'h01, 32'h00003300, w);
        issue(4'b0100, 8'h00, 32'h00330000, w);
        got_q.delete();
        got_cyc.delete();
        issue(4'h0, 8'h00, 32'h0, w);
        issue(4'h0, 8'h01, 32'h0, w);
        issue(4'h0, 8'h02, 32'h0, w);
        idle();
        step(6);
        chk("mask_count", got_q.size(), 3);
        chk("mask_rsp0", got_q[0], 32'hAA3355BB);
        chk("mask_rsp1", got_q[1], 32'hAA0033CC);
        chk("mask_rsp2", got_q[2], 32'hAA005533);

        // Streaming reads with the consumer always ready.
        issue(4'hF, 8'hF0, 32'h11110000, w);
        issue(4'hF, 8'hF1, 32'h22220001, w);
        issue(4'hF, 8'hF2, 32'h33330002, w);
        got_q.delete();
        got_cyc.delete();
        stalls = 0;
        issue(4'h0, 8'hF0, 32'h0, w); stalls += w;
        issue(4'h0, 8'hF1, 32'h0, w); stalls += w;
        issue(4'h0, 8'hF2, 32'h0, w); stalls += w;
        idle();
        step(6);
        chk("stream_stalls", stalls, 0);
        chk("stream_count", got_q.size(), 3);
        chk("stream_gap01", got_cyc[1] - got_cyc[0], 1);
        chk("stream_gap12", got_cyc[2] - got_cyc[1], 1);
        chk("stream_rsp2", got_q[2], 32'h33330002);

        // Back-pressure: only RSP_DEPTH reads get in while the consumer stalls.
        bus.rsp_ready = 1'b0;
        got_q.delete();
        got_cyc.delete();
        acc_cnt = 0;
        issue(4'h0, 8'h00, 32'h0, w);
        issue(4'h0, 8'h01, 32'h0, w);
        issue(4'h0, 8'h02, 32'h0, w);
        issue(4'h0, 8'hF0, 32'h0, w);
        bus.req_addr = 8'hF1;
        step(5);
        @(negedge clk);
        chk("bp_req_ready", bus.req_ready, 1'b0);
        chk("bp_accepted", acc_cnt, 4);
        chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
        chk("bp_none_popped", got_q.size(), 0);
        step(1);
        bus.rsp_ready = 1'b1;
        issue(4'h0, 8'hF1, 32'h0, w);
        issue(4'h0, 8'hF2, 32'h0, w);
        idle();
        step(10);
        chk("bp_accepted_all", acc_cnt, 6);
        chk("bp_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("bp_rsp%0d", i), got_q[i], bp_exp[i]);

        // Reset one cycle after a read is accepted discards it.
        got_q.delete();
        got_cyc.delete();
        issue(4'h0, 8'h02, 32'h0, w);
        idle();
        rst = 1'b1;
        step(1);
        @(negedge clk);
        chk("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
        step(1);
        rst = 1'b0;
        wait_init(n);
        chk("rst_mid_init_latency", n, INIT_CYCLES);
        step(8);
        chk("rst_mid_no_stale", got_q.size(), 0);
        issue(4'h0, 8'h00, 32'h0, w);
        idle();
        step(4);
        chk("rst_mid_count", got_q.size(), 1);
        chk("rst_mid_mem", got_q[0], INIT_BUILD ? 32'h0 : 32'hAA3355BB);

        // Never-written top word: zero after a sweep, power-up image otherwise.
        got_q.delete();
        got_cyc.delete();
        issue(4'h0, 8'hFF, 32'h0, w);
        idle();
        step(4);
        chk("top_word", got_q[0], INIT_BUILD ? 32'h0 : 32'hC0DE00FF);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/dffram_req_ctrl.md
# dffram_req_ctrl

Request/response front-end that sits directly upstream of the DFFRAM256x32 macro and is the only agent driving its single port. It accepts byte-masked read/write requests over a valid/ready handshake and converts them into single-cycle EN0/WE0/A0/Di0 strobes. Read data is captured into a response FIFO so a stalled consumer never loses RAM output. An optional post-reset sweep zero-fills the whole array.

## Interface
Parameters:
- AW, 8, word-address width (2^AW words)
- WSIZE, 4, bytes per word; data width is 8*WSIZE
- RSP_DEPTH, 4, response FIFO entries (power of two, ≥2)

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready at an edge
- req_we  in  WSIZE  byte write mask; zero means read
- req_addr  in  AW  word address
- req_wdata  in  8*WSIZE  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes data when valid&ready at an edge
- rsp_rdata  out  8*WSIZE  read data, FIFO head
- ram_EN0  out  1  to RAM EN0
- ram_WE0  out  WSIZE  to RAM WE0
- ram_A0  out  AW  to RAM A0
- ram_Di0  out  8*WSIZE  to RAM Di0
- ram_Do0  in  8*WSIZE  from RAM Do0
- init_done  out  1  array ready for traffic

## Operation
- States: INIT (only with INIT_CLEAR_EN), RUN. Reset state: INIT if macro defined, else RUN.
- Reset values: req_ready 0, rsp_valid 0, init_done 0, ram_EN0 0, ram_WE0 0; FIFO empty, in-flight flag 0.
- RUN: req_ready = (fifo_count + inflight) < RSP_DEPTH. Registered terms only; no combinational path from rsp_ready or req_* to req_ready.
- RAM port is combinational from the request in RUN: ram_A0 = req_addr, ram_Di0 = req_wdata, ram_EN0 = req_valid & req_ready, ram_WE0 = req_we when accepted, else 0.
- Write (req_we ≠ 0): only masked bytes are updated. No response is generated.
- Read (req_we = 0): sets inflight. In the next cycle, ram_Do0 is pushed into the FIFO at the edge, and inflight clears unless another read was accepted in that cycle.
- FIFO: rsp_valid = count ≠ 0. Push and pop in the same cycle are allowed, and count is unchanged. The pointer wraps modulo RSP_DEPTH.
- Ordering: responses return in request order. A read accepted in the cycle after a write to the same address returns the new data.
- Reset mid-operation: in-flight read and all FIFO contents are discarded. rsp_valid drops the cycle after the RST edge. In RUN builds, RAM contents are untouched.

## Timing
- Read accepted at edge E0. Do0 is valid during the cycle after E0, pushed at E1, and rsp_valid is high after E1. Load-to-use latency is 2 cycles.
- Full throughput: with rsp_ready held at 1, one read is accepted per cycle. Steady-state occupancy ≤ 2, so RSP_DEPTH = 4 never stalls.
- Back-pressure: with rsp_ready = 0, at most RSP_DEPTH reads are accepted, and req_ready then stays 0. Writes are also blocked, because req_ready is independent of req_we.
- Write takes effect at its acceptance edge.
- init_done, non-INIT build: 1 from the first edge with RST = 0.

## Configuration
- INIT_CLEAR_EN defined:
  - After reset the block enters INIT, with req_ready = 0 and init_done = 0.
  - It issues 2^AW consecutive writes, addresses 0 … 2^AW−1 ascending, one per cycle, with ram_WE0 all ones and ram_Di0 = 0.
  - It enters RUN on the edge after the last write, and init_done rises then (2^AW cycles after reset release).
  - RST during INIT restarts the sweep at address 0.
- INIT_CLEAR_EN undefined: the INIT state and address counter are absent, and RAM contents after power-up are undefined.

## Test plan
- Full-word write/readback: write 0x00=AA0055BB, 0x01=AA0055CC, 0x02=AA0055DD (mask 1111); read 0x00 → rsp_rdata AA0055BB exactly 2 cycles after acceptance.
- Byte masks: write 0x02=00000033/0001, 0x01=00003300/0010, 0x00=00330000/0100; reads 0x00,0x01,0x02 → AA3355BB, AA0033CC, AA005533, in order.
- Streaming: back-to-back reads of 0xF0,0xF1,0xF2 with rsp_ready = 1 → req_ready never drops; three responses on consecutive cycles.
- Back-pressure: rsp_ready = 0, issue 6 reads → exactly 4 accepted and req_ready = 0. Release rsp_ready → 4 ordered responses, then the remaining 2 are accepted.
- Reset mid-flight: assert RST one cycle after a read is accepted → rsp_valid = 0 after the reset edge; no stale response appears afterwards.
- INIT_CLEAR_EN: after reset, init_done rises 256 cycles later; read 0xFF → 00000000; req_ready = 0 throughout the sweep.
